// File: rtl/sar_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sar_ctrl_pkg
// Shared definitions for the SAR ADC controller: FSM state encoding, default
// parameter values and the start-to-done latency helper.
// ----------------------------------------------------------------------------
package sar_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_SETTLE = 3'd2,
      ST_DECIDE = 3'd3,
      ST_DONE   = 3'd4
   } sar_state_e;

   localparam int DEF_WIDTH         = 8;
   localparam int DEF_SAMPLE_CYCLES = 4;
   localparam int DEF_SETTLE_CYCLES = 2;

   // Number of edges from the edge that accepts start to the edge after
   // which done is high.
   function automatic int conv_latency(input int width,
                                       input int sample_cycles,
                                       input int settle_cycles);
      return sample_cycles + width * (settle_cycles + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchronizer for an asynchronous level input.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset (flops clear to 0)
//   i_async  in  asynchronous input
//   o_sync   out synchronized copy, two clocks of latency
// ----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_ff1;
   logic r_ff2;

   // NOTE: non-blocking assignments make both flops sample on the same edge;
   // blocking ones would collapse the chain into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ff1 <= 1'b0;
         r_ff2 <= 1'b0;
      end else begin
         r_ff1 <= i_async;
         r_ff2 <= r_ff1;
      end
   end

   assign o_sync = r_ff2;

endmodule

// File: rtl/sar_adc_ctrl.sv
// ----------------------------------------------------------------------------
// sar_adc_ctrl
// Successive-approximation controller driving an external R-2R DAC and
// reading the on-chip comparator. One track phase, then one bit per
// SETTLE_CYCLES+1 clocks, MSB first; result returned with a done pulse.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   start     in  begin a conversion (accepted only in IDLE)
//   abort     in  cancel the running conversion; beats start in IDLE
//   cmp_in    in  asynchronous comparator output, 1 = Vip above DAC level
//   sample    out high during the track phase
//   dac_code  out registered trial code to the DAC
//   busy      out high whenever not IDLE
//   done      out one-cycle pulse, result valid from this cycle
//   result    out last completed conversion
// ----------------------------------------------------------------------------
module sar_adc_ctrl
   import sar_ctrl_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_in,
   output logic             sample,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(max2(SAMPLE_CYCLES, SETTLE_CYCLES));
   localparam int IDX_W = $clog2(WIDTH);

   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);

   sar_state_e       r_state;
   sar_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_dn;
   logic [WIDTH-1:0] r_code;
   logic [WIDTH-1:0] r_result;
   logic             w_cmp_s;

   sync_2ff u_cmp_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (cmp_in),
      .o_sync  (w_cmp_s)
   );

   assign w_idx_dn = r_idx - IDX_W'(1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   // NOTE: w_state_nxt gets its default before the case so every path
   // assigns it and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start && !abort) w_state_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (abort)                     w_state_nxt = ST_IDLE;
            else if (r_cnt == SAMPLE_LAST) w_state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (abort)                     w_state_nxt = ST_IDLE;
            else if (r_cnt == SETTLE_LAST) w_state_nxt = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (abort)            w_state_nxt = ST_IDLE;
            else if (r_idx == '0) w_state_nxt = ST_DONE;
            else                  w_state_nxt = ST_SETTLE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Phase counter, bit index, working code and result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_code   <= '0;
         r_result <= '0;
      end else begin
         // Counter restarts whenever the phase changes and idles at zero.
         if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         unique case (r_state)
            ST_IDLE: begin
               if (w_state_nxt == ST_SAMPLE) begin
                  r_code <= '0;
                  r_idx  <= IDX_MSB;
               end
            end
            ST_SAMPLE: begin
               if (w_state_nxt == ST_SETTLE) r_code[r_idx] <= 1'b1;
            end
            ST_DECIDE: begin
               // An abort leaves both code and result untouched.
               if (w_state_nxt == ST_SETTLE) begin
                  r_code[r_idx]    <= w_cmp_s;
                  r_code[w_idx_dn] <= 1'b1;
                  r_idx            <= w_idx_dn;
               end else if (w_state_nxt == ST_DONE) begin
                  r_code[0] <= w_cmp_s;
                  r_result  <= {r_code[WIDTH-1:1], w_cmp_s};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sample   = (r_state == ST_SAMPLE);
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);
   assign dac_code = r_code;
   assign result   = r_result;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sar_adc_ctrl
// Self-checking bench for sar_adc_ctrl with a behavioural comparator and a
// binary-search reference model of the expected DAC trials and result.
// ----------------------------------------------------------------------------
module tb_sar_adc_ctrl;
   import sar_ctrl_pkg::*;

   localparam int W   = DEF_WIDTH;
   localparam int S   = DEF_SAMPLE_CYCLES;
   localparam int SET = DEF_SETTLE_CYCLES;
   localparam int T   = conv_latency(W, S, SET);

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic         cmp_in;
   logic         sample;
   logic [W-1:0] dac_code;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int mode;        // 0: Vin model, 1: constant 0, 2: constant 1
   int vin;
   int checks      = 0;
   int failures    = 0;
   int prev_result = 0;

   always #5 clk = ~clk;

   sar_adc_ctrl #(
      .WIDTH         (W),
      .SAMPLE_CYCLES (S),
      .SETTLE_CYCLES (SET)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .cmp_in   (cmp_in),
      .sample   (sample),
      .dac_code (dac_code),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   function automatic logic model_cmp(input int m, input int v, input int trial);
      if (m == 1) return 1'b0;
      if (m == 2) return 1'b1;
      return (trial <= v);
   endfunction

   always_comb begin
      cmp_in = 1'b0;
      cmp_in = model_cmp(mode, vin, int'(dac_code));
   end

   task automatic check(input string tag, input int k,
                        input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag, input int k);
      check({tag, ".sample"}, k, 32'(sample), 32'd0);
      check({tag, ".busy"},   k, 32'(busy),   32'd0);
      check({tag, ".done"},   k, 32'(done),   32'd0);
      check({tag, ".dac"},    k, 32'(dac_code), 32'd0);
      check({tag, ".result"}, k, 32'(result), 32'd0);
   endtask

   // One conversion. pa/pb: extra start pulses; ab_edge: abort edge;
   // rst_edge: async reset right after that edge. -1 disables each.
   task automatic run_conv(input int m, input int v, input int pa, input int pb,
                           input int ab_edge, input int rst_edge);
      int trials[W];
      int code;
      int exp_res;
      int exp_dac;
      mode = m;
      vin  = v;
      code = 0;
      for (int j = 0; j < W; j++) begin
         trials[j] = code | (1 << (W - 1 - j));
         if (model_cmp(m, v, trials[j])) code = trials[j];
      end
      exp_res = code;

      for (int k = 0; k <= T + 2; k++) begin
         start = (k == 0) || (k == pa) || (k == pb);
         abort = (k == ab_edge);
         tick();
         if (k == ab_edge) begin
            start = 1'b0;
            abort = 1'b0;
            check("abort.busy",   k, 32'(busy),   32'd0);
            check("abort.done",   k, 32'(done),   32'd0);
            check("abort.result", k, 32'(result), 32'(prev_result));
            for (int i = 1; i <= 3; i++) begin
               tick();
               check("abort.idle_done",   k + i, 32'(done),   32'd0);
               check("abort.idle_busy",   k + i, 32'(busy),   32'd0);
               check("abort.idle_result", k + i, 32'(result), 32'(prev_result));
            end
            return;
         end
         if (k == rst_edge) begin
            start = 1'b0;
            #2 rst_n = 1'b0;
            #1 check_all_zero("midreset", k);
            #2 rst_n = 1'b1;
            prev_result = 0;
            return;
         end
         check("done",   k, 32'(done),   32'(k == T));
         check("busy",   k, 32'(busy),   32'(k <= T));
         check("sample", k, 32'(sample), 32'(k < S));
         if (k < T) begin
            exp_dac = (k < S) ? 0 : trials[(k - S) / (SET + 1)];
            check("dac", k, 32'(dac_code), 32'(exp_dac));
         end
         check("result", k, 32'(result), 32'((k >= T) ? exp_res : prev_result));
      end
      start = 1'b0;
      prev_result = exp_res;
   endtask

   // start held high: two conversions separated by one IDLE cycle.
   task automatic run_held(input int v);
      mode  = 0;
      vin   = v;
      start = 1'b1;
      for (int k = 0; k <= 2 * T + 3; k++) begin
         tick();
         check("held.done", k, 32'(done), 32'((k == T) || (k == 2 * T + 2)));
         check("held.busy", k, 32'(busy), 32'(!((k == T + 1) || (k == 2 * T + 3))));
      end
      start = 1'b0;
      check("held.result", 2 * T + 3, 32'(result), 32'(v));
      prev_result = v;
   endtask

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog edge=-1 observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v;
      rst_n = 1'b0;
      start = 1'b1;
      abort = 1'b0;
      mode  = 2;
      vin   = 0;
      repeat (3) tick();
      check_all_zero("reset", 0);
      rst_n = 1'b1;
      run_conv(2, 0, -1, -1, -1, -1);         // begins on first edge, 0xFF

      run_conv(0, 'hA5, -1, -1, -1, -1);
      run_conv(1, 0, -1, -1, -1, -1);
      run_conv(2, 0, -1, -1, -1, -1);
      for (int i = 0; i < 4; i++) begin
         v = int'($urandom_range(0, (1 << W) - 1));
         run_conv(0, v, -1, -1, -1, -1);
      end
      run_conv(0, 0, -1, -1, -1, -1);
      run_conv(0, (1 << W) - 1, -1, -1, -1, -1);

      // Abort at the exit of the DECIDE for bit index 4.
      run_conv(0, 'h3C, -1, -1, -1, -1);
      repeat (2) tick();
      run_conv(0, 'h5A, -1, -1, S + (W - 1 - 4) * (SET + 1) + SET + 1, -1);

      run_conv(0, 'hA5, 5, T, -1, -1);
      repeat (2) tick();
      run_held(int'($urandom_range(0, (1 << W) - 1)));
      repeat (2) tick();

      run_conv(0, 'h77, -1, -1, -1, 15);
      tick();
      run_conv(0, 'hA5, -1, -1, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
